// File: rtl/fec_sched_pkg.sv
// fec_sched_pkg: scheduler FSM state type and FEC frame constants shared by crc_frame_sched.
package fec_sched_pkg;
    typedef enum logic [2:0] {IDLE, ARB, SEND, WAIT_REQ, WAIT_END, DRAIN} sched_state_t;
    localparam int FEC_FRAME_BITS = 1904;
    localparam int FEC_CRC_BITS   = 16;
endpackage

// File: rtl/crc_frame_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    localparam int IW = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IW-1:0]      idx
);
    logic [2*NUM_SRC-1:0] rot;
    int s;
    assign rot = {req, req} >> ptr;
    always_comb begin
        idx = '0;
        s = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (rot[k]) idx = IW'(s >= NUM_SRC ? s - NUM_SRC : s);
        end
    end
    assign gnt = |req ? NUM_SRC'(1) << idx : '0;
endmodule

// File: rtl/crc_frame_sched.sv
// crc_frame_sched: round-robin scheduler sharing one bit-serial CRC coder between NUM_SRC frame sources.
// Define SCHED_STATS_EN to add per-source completed-frame counters on frm_cnt.
module crc_frame_sched
    import fec_sched_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FRAME_BITS = FEC_FRAME_BITS,
    parameter int CRC_BITS   = FEC_CRC_BITS,
    parameter int REQ_TMO    = 64,
    localparam int IW = $clog2(NUM_SRC),
    localparam int BW = $clog2(FRAME_BITS + 1),
    localparam int TW = $clog2(REQ_TMO + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [NUM_SRC-1:0] src_rdy,
    input  logic [NUM_SRC-1:0] src_dat,
    output logic [NUM_SRC-1:0] src_rd,
    output logic               cod_val,
    output logic               cod_sop,
    output logic               cod_dat,
    input  logic               cod_req,
    output logic               busy,
    output logic [IW-1:0]      grant_id,
    output logic               err_tmo
`ifdef SCHED_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0] frm_cnt
`endif
);
    sched_state_t state, nxt;
    logic [BW-1:0] bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [IW-1:0] ptr, idx;
    logic [NUM_SRC-1:0] gnt, grant_oh;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) arb (.req(src_rdy), .ptr(ptr), .gnt(gnt), .idx(idx));

    assign busy    = state != IDLE && state != ARB;
    assign cod_val = state == SEND;
    assign cod_sop = cod_val && bit_cnt == '0;
    assign src_rd  = cod_val ? grant_oh : '0;
    assign cod_dat = cod_val && |(src_dat & grant_oh);
    assign err_tmo = state == WAIT_REQ && !cod_req && tmo_cnt == TW'(REQ_TMO - 1);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = ena ? ARB : IDLE;
            ARB:      nxt = !ena ? IDLE : |src_rdy ? SEND : ARB;
            SEND:     nxt = bit_cnt == BW'(FRAME_BITS - 1) ? WAIT_REQ : SEND;
            WAIT_REQ: nxt = cod_req ? WAIT_END : err_tmo ? ARB : WAIT_REQ;
            WAIT_END: nxt = cod_req ? WAIT_END : DRAIN;
            DRAIN:    nxt = bit_cnt == BW'(CRC_BITS - 1) ? ARB : DRAIN;
            default:  nxt = IDLE;
        endcase
    end

    // bit_cnt counts payload bits in SEND and CRC bits in DRAIN; both counters restart on state entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            ptr      <= '0;
            grant_id <= '0;
            grant_oh <= NUM_SRC'(1);
        end else begin
            state   <= nxt;
            bit_cnt <= (nxt == state && (state == SEND || state == DRAIN)) ? bit_cnt + 1'b1 : '0;
            tmo_cnt <= (state == WAIT_REQ && nxt == WAIT_REQ) ? tmo_cnt + 1'b1 : '0;
            if (state == ARB && nxt == SEND) begin
                grant_id <= idx;
                grant_oh <= gnt;
                ptr      <= idx == IW'(NUM_SRC - 1) ? '0 : idx + 1'b1;
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) frm_cnt <= '0;
        else if (state == DRAIN && nxt == ARB)
            frm_cnt[16*grant_id +: 16] <= frm_cnt[16*grant_id +: 16] + 16'd1;
    end
`endif
endmodule

// File: tb/tb_crc_frame_sched.sv
// tb_crc_frame_sched: randomized scoreboard bench for crc_frame_sched with a reactive coder model.
// Checks frm_cnt as well when built with SCHED_STATS_EN.
module tb_crc_frame_sched;
    localparam int NS = 2, FB = 1904, CB = 16, TMO = 64, SQ = 30000;
    typedef struct { int cyc; int src; } frm_t;
    typedef struct { bit d; bit sop; int src; } bit_t;

    logic clk = 0, rst = 0, ena = 0, cod_req = 0;
    logic [NS-1:0] src_rdy = '0, src_dat = '0, src_rd;
    logic cod_val, cod_sop, cod_dat, busy, err_tmo;
    logic [0:0] grant_id;
`ifdef SCHED_STATS_EN
    logic [NS*16-1:0] frm_cnt;
`endif

    crc_frame_sched #(.NUM_SRC(NS), .FRAME_BITS(FB), .CRC_BITS(CB), .REQ_TMO(TMO)) dut (
        .clk(clk), .rst(rst), .ena(ena), .src_rdy(src_rdy), .src_dat(src_dat), .src_rd(src_rd),
        .cod_val(cod_val), .cod_sop(cod_sop), .cod_dat(cod_dat), .cod_req(cod_req),
        .busy(busy), .grant_id(grant_id), .err_tmo(err_tmo)
`ifdef SCHED_STATS_EN
        , .frm_cnt(frm_cnt)
`endif
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit sq [NS][SQ];
    int rp [NS], mp [NS], cnt [NS];
    frm_t fq [$];
    bit_t bq [$];
    int eq [$];
    int nb = 0, rr = 0, m_src = 0, arb_cyc = -1, req_on = -1, req_off = -1, rst_chk = -1, frames = 0;
    bit m_idle = 1, tmo_mode = 0;
    logic nx_rst = 0, nx_ena = 0;
    logic [NS-1:0] nx_rdy = '0;
    int n_cmp = 0, n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endfunction

    // Reference arbitration: first ready source at or after the round-robin pointer
    function automatic void predict(int c);
        int g = 0;
        for (int i = NS - 1; i >= 0; i--) if (src_rdy[(rr + i) % NS]) g = (rr + i) % NS;
        fq.push_back('{c, g});
        for (int b = 0; b < FB; b++) bq.push_back('{sq[g][mp[g] + b], b == 0, g});
        mp[g] += FB;
        rr = (g + 1) % NS;
        m_src = g;
    endfunction

    function automatic void end_frame(int l);
        nb = 0;
        frames++;
        if (tmo_mode) begin
            eq.push_back(l + TMO);
            arb_cyc = l + TMO + 1;
        end else begin
            req_on  = l + 1 + int'($urandom_range(0, 8));
            req_off = req_on + int'($urandom_range(1, 8));
            arb_cyc = req_off + CB + 1;
            cnt[m_src]++;
        end
    endfunction

    task automatic step();
        logic [NS-1:0] rd_s;
        logic val_s;
        @(negedge clk);
        rd_s = src_rd;
        val_s = cod_val;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) if (rd_s[i] === 1'b1) rp[i]++;
        if (val_s === 1'b1) begin
            nb++;
            if (nb == FB) end_frame(cyc - 1);
        end
        if (!rst) begin
            fq.delete(); bq.delete(); eq.delete();
            for (int i = 0; i < NS; i++) begin mp[i] = rp[i]; cnt[i] = 0; end
            nb = 0; rr = 0; arb_cyc = -1; req_on = -1; req_off = -1; m_idle = 1; rst_chk = cyc;
        end
        rst = nx_rst; ena = nx_ena; src_rdy = nx_rdy;
        for (int i = 0; i < NS; i++) src_dat[i] = sq[i][rp[i]];
        cod_req = cyc >= req_on && cyc < req_off;
        if (arb_cyc == cyc) begin
            if (!ena) begin m_idle = 1; arb_cyc = -1; end
            else if (src_rdy != 0) begin predict(cyc + 1); arb_cyc = -1; end
            else arb_cyc++;
        end else if (m_idle && ena) begin
            m_idle = 0;
            arb_cyc = cyc + 1;
        end
    endtask

    task automatic run_frames(int n);
        int t = frames + n;
        for (int k = 0; k < n * 2500 && frames < t; k++) step();
        check("frames_done", frames >= t, 1);
    endtask

    task automatic run_bits(int b);
        for (int k = 0; k < 5000 && nb != b; k++) step();
        check("bit_reached", nb == b, 1);
    endtask

    always @(negedge clk) begin
        frm_t fr;
        bit_t eb;
        bit e;
        e = 0;
        if (eq.size() > 0 && eq[0] == cyc) begin e = 1; void'(eq.pop_front()); end
        check("err_tmo", err_tmo, e);
        if (cyc == rst_chk)
            check("reset_outputs", {src_rd, cod_val, cod_sop, cod_dat, busy, err_tmo, grant_id}, 0);
        if (cod_val === 1'b1) begin
            if (cod_sop === 1'b1) begin
                check("frame_expected", fq.size() > 0, 1);
                if (fq.size() > 0) begin
                    fr = fq.pop_front();
                    check("sop_cycle", cyc, fr.cyc);
                    check("grant_id", grant_id, fr.src);
                end
            end
            check("bit_expected", bq.size() > 0, 1);
            if (bq.size() > 0) begin
                eb = bq.pop_front();
                check("cod_sop", cod_sop, eb.sop);
                check("cod_dat", cod_dat, eb.d);
                check("src_rd", src_rd, 1 << eb.src);
                check("busy_send", busy, 1);
            end
        end else begin
            check("src_rd_idle", src_rd, 0);
            check("cod_sop_idle", cod_sop, 0);
        end
    end

    initial begin
        for (int i = 0; i < NS; i++) begin
            rp[i] = 0; mp[i] = 0; cnt[i] = 0;
            for (int j = 0; j < SQ; j++) sq[i][j] = 1'($urandom);
        end
        nx_rdy = 2'b01;
        nx_ena = 1;
        repeat (3) step();
        nx_rst = 1;
        run_frames(2);
        nx_rdy = 2'b11;
        run_frames(4);
        nx_rdy = 2'b10;
        run_frames(2);
        tmo_mode = 1;
        run_frames(1);
        tmo_mode = 0;
        run_frames(1);
        run_bits(1000);
        nx_rst = 0;
        step();
        nx_rst = 1;
        step();
        nx_rdy = 2'b11;
        run_frames(3);
        run_bits(500);
        nx_ena = 0;
        for (int k = 0; k < 3000 && !m_idle; k++) step();
        check("went_idle", m_idle, 1);
        repeat (5) step();
        check("idle_busy", busy, 0);
        check("idle_val", cod_val, 0);
        check("queues_empty", fq.size() + bq.size() + eq.size(), 0);
`ifdef SCHED_STATS_EN
        check("frm_cnt", frm_cnt, {cnt[1][15:0], cnt[0][15:0]});
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
